// File: rtl/spi_target_regs.sv
`default_nettype none
// ============================================================================
//  Module   : spi_target_regs
//  Purpose  : SPI mode-0 target with an 8-bit register file. Frames are
//             8 command bits (bit 7 = write, bits 6:0 = address), one gap
//             edge, then 8 data bits. All SPI pins are synchronised and
//             edge-detected in the pclk domain.
//  Optional : define SPI_TGT_MSB_FIRST_EN to shift command/data MSB first
//             (default is LSB first).
//  Ports    : pclk_i, prst_i (async, active-low)       - clock / reset
//             sclk_i, ss_i, mosi_i                     - SPI inputs (async)
//             miso_o, miso_oe_o                        - SPI read data / enable
//             lcl_addr_i, lcl_rdata_o                  - local read port
//             wr_pulse_o, wr_addr_o, wr_data_o         - last SPI write event
//             frame_err_o                              - abort / range error
//  Revision : 1.0 - initial release
// ============================================================================
module spi_target_regs #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          pclk_i,
  input  logic          prst_i,
  input  logic          sclk_i,
  input  logic          ss_i,
  input  logic          mosi_i,
  output logic          miso_o,
  output logic          miso_oe_o,
  input  logic [AW-1:0] lcl_addr_i,
  output logic [7:0]    lcl_rdata_o,
  output logic          wr_pulse_o,
  output logic [6:0]    wr_addr_o,
  output logic [7:0]    wr_data_o,
  output logic          frame_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_GAP  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  logic [1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic       sclk_prev_q;
  logic       armed_q, armed_d;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] snap_q, snap_d;
  logic       miso_q, miso_d;
  logic       oe_q, oe_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       err_q, err_d;
  logic [7:0] regs_q [DEPTH];
  logic       reg_we;

  logic          sclk_s, ss_s, mosi_s;
  logic          sclk_rise, sclk_fall;
  logic          addr_ok, lcl_ok;
  logic [AW-1:0] cmd_idx;
  logic [7:0]    data_next;
  logic          miso_bit;

  // Inserts one received bit into a byte so that after eight calls the
  // byte holds the transmitted value in its natural bit positions.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
`ifdef SPI_TGT_MSB_FIRST_EN
    return {cur[6:0], b};
`else
    return {b, cur[7:1]};
`endif
  endfunction

  assign sclk_s    = sclk_sync_q[1];
  assign ss_s      = ss_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign cmd_idx   = cmd_q[AW-1:0];
  assign addr_ok   = ({1'b0, cmd_q[6:0]} < 8'(DEPTH));
  assign lcl_ok    = ({1'b0, lcl_addr_i} < (AW+1)'(DEPTH));
  assign data_next = shift_in(shift_q, mosi_s);

  // In the data phase cnt_q counts completed data rising edges, which is
  // exactly the index of the bit to present on the current falling edge.
`ifdef SPI_TGT_MSB_FIRST_EN
  assign miso_bit = snap_q[3'd7 - cnt_q];
`else
  assign miso_bit = snap_q[cnt_q];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    shift_d    = shift_q;
    snap_d     = snap_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    reg_we     = 1'b0;
    // A frame may only start after ss has been observed high since reset.
    armed_d    = armed_q | ss_s;

    if (ss_s) begin
      // Deselect: release miso at once; anything but a frame boundary aborts.
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      if (state_q != S_IDLE && !(state_q == S_CMD && cnt_q == 3'd0)) begin
        err_d = 1'b1;
      end
    end else begin
      if (sclk_fall) begin
        if (state_q == S_DATA && !cmd_q[7]) begin
          oe_d   = 1'b1;
          miso_d = miso_bit;
        end else begin
          oe_d   = 1'b0;
          miso_d = 1'b0;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            state_d = S_CMD;
            cnt_d   = 3'd0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            cmd_d = shift_in(cmd_q, mosi_s);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (sclk_rise) begin
            snap_d  = addr_ok ? regs_q[cmd_idx] : 8'h00;
            state_d = S_DATA;
            cnt_d   = 3'd0;
          end
        end
        S_DATA: begin
          if (sclk_rise) begin
            shift_d = data_next;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = S_CMD;
              if (!addr_ok) begin
                err_d = 1'b1;
              end else if (cmd_q[7]) begin
                reg_we     = 1'b1;
                wr_pulse_d = 1'b1;
                wr_addr_d  = cmd_q[6:0];
                wr_data_d  = data_next;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      sclk_sync_q <= 2'b00;
      ss_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      cmd_q       <= 8'h00;
      shift_q     <= 8'h00;
      snap_q      <= 8'h00;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= 7'h00;
      wr_data_q   <= 8'h00;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      ss_sync_q   <= {ss_sync_q[0], ss_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      sclk_prev_q <= sclk_s;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      snap_q      <= snap_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      if (reg_we) regs_q[cmd_idx] <= data_next;
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = oe_q;
  assign wr_pulse_o  = wr_pulse_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_err_o = err_q;
  assign lcl_rdata_o = lcl_ok ? regs_q[lcl_addr_i] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_spi_target_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_target_regs
//  Purpose  : Self-checking bench for spi_target_regs. A driver issues SPI
//             frames and records the expected strobes / read bytes; monitor
//             processes compare them against what the target produces.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target_regs;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int HALF  = 60;   // sclk half period in ns (pclk is 10 ns)

  logic          pclk_i = 1'b0;
  logic          prst_i = 1'b0;
  logic          sclk_i = 1'b0;
  logic          ss_i   = 1'b1;
  logic          mosi_i = 1'b0;
  logic          miso_o, miso_oe_o;
  logic [AW-1:0] lcl_addr_i = '0;
  logic [7:0]    lcl_rdata_o;
  logic          wr_pulse_o;
  logic [6:0]    wr_addr_o;
  logic [7:0]    wr_data_o;
  logic          frame_err_o;

  spi_target_regs #(.DEPTH(DEPTH), .AW(AW)) dut (
    .pclk_i      (pclk_i),
    .prst_i      (prst_i),
    .sclk_i      (sclk_i),
    .ss_i        (ss_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .lcl_addr_i  (lcl_addr_i),
    .lcl_rdata_o (lcl_rdata_o),
    .wr_pulse_o  (wr_pulse_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .frame_err_o (frame_err_o)
  );

  always #5 pclk_i = ~pclk_i;

  typedef struct {
    bit         is_err;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_ev_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] got_rd_q[$];
  logic [7:0] mem [DEPTH];
  int         n_cmp = 0;
  int         n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe monitor: every wr_pulse / frame_err must match the next expected event.
  ev_t mon_ev;
  always @(negedge pclk_i) begin
    if (prst_i) begin
      if (wr_pulse_o) begin
        if (exp_ev_q.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL wr_pulse_unexpected: got pulse addr %0h data %0h, expected none", wr_addr_o, wr_data_o);
        end else begin
          mon_ev = exp_ev_q.pop_front();
          chk("wr_kind_is_err", 0, mon_ev.is_err);
          chk("wr_addr", wr_addr_o, mon_ev.addr);
          chk("wr_data", wr_data_o, mon_ev.data);
        end
      end
      if (frame_err_o) begin
        if (exp_ev_q.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL frame_err_unexpected: got pulse, expected none");
        end else begin
          mon_ev = exp_ev_q.pop_front();
          chk("err_kind_is_err", 1, mon_ev.is_err);
        end
      end
    end
  end

  // Read-data monitor: each byte captured from miso is matched to the model.
  logic [7:0] mon_got;
  always @(negedge pclk_i) begin
    if (got_rd_q.size() > 0) begin
      mon_got = got_rd_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL rd_unexpected: got %0h, expected no read", mon_got);
      end else begin
        chk("rd_data", mon_got, exp_rd_q.pop_front());
      end
    end
  end

  function automatic bit tx_bit(input logic [7:0] v, input int k);
`ifdef SPI_TGT_MSB_FIRST_EN
    return v[7-k];
`else
    return v[k];
`endif
  endfunction

  function automatic logic [7:0] rx_bit(input logic [7:0] v, input bit b, input int k);
    logic [7:0] r;
    r = v;
`ifdef SPI_TGT_MSB_FIRST_EN
    r[7-k] = b;
`else
    r[k] = b;
`endif
    return r;
  endfunction

  task automatic sclk_edge(input bit m, output bit mi, output bit oe);
    mosi_i = m;
    #(HALF);
    sclk_i = 1'b1;
    mi = miso_o;
    oe = miso_oe_o;
    #(HALF);
    sclk_i = 1'b0;
  endtask

  task automatic ss_assert();
    ss_i = 1'b0;
    #(HALF);
  endtask

  task automatic ss_release();
    ss_i = 1'b1;
    #(2*HALF);
    chk("oe_after_ss", miso_oe_o, 0);
  endtask

  // One frame; stop_edge != 0 releases ss after that rising edge (abort).
  task automatic frame(input logic [7:0] cmd, input logic [7:0] data, input int stop_edge);
    logic [6:0] addr;
    bit         in_rng, is_rd, mi, oe, oe_bad, m;
    logic [7:0] rd;
    int         last;
    ev_t        ev;
    addr   = cmd[6:0];
    in_rng = (int'(addr) < DEPTH);
    is_rd  = !cmd[7];
    oe_bad = 1'b0;
    rd     = 8'h00;
    last   = (stop_edge == 0) ? 17 : stop_edge;
    ev.addr = addr;
    ev.data = data;
    ev.is_err = 1'b1;
    if (stop_edge != 0) begin
      exp_ev_q.push_back(ev);
    end else if (!is_rd) begin
      if (in_rng) begin
        mem[addr[AW-1:0]] = data;
        ev.is_err = 1'b0;
      end
      exp_ev_q.push_back(ev);
    end else begin
      exp_rd_q.push_back(in_rng ? mem[addr[AW-1:0]] : 8'h00);
      if (!in_rng) exp_ev_q.push_back(ev);
    end
    for (int e = 1; e <= last; e++) begin
      if (e <= 8)       m = tx_bit(cmd, e-1);
      else if (e == 9)  m = 1'($urandom);
      else              m = tx_bit(data, e-10);
      sclk_edge(m, mi, oe);
      if (oe !== (is_rd && e >= 10)) oe_bad = 1'b1;
      if (e >= 10) rd = rx_bit(rd, mi, e-10);
    end
    if (stop_edge != 0) begin
      #(HALF);
      ss_i = 1'b1;
      #(2*HALF);
      chk("oe_after_abort", miso_oe_o, 0);
    end else begin
      #(HALF);
      if (miso_oe_o !== 1'b0) oe_bad = 1'b1;
      chk("oe_window", oe_bad, 0);
      if (is_rd) got_rd_q.push_back(rd);
    end
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      lcl_addr_i = AW'(a);
      #10;
      chk(tag, lcl_rdata_o, mem[a]);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},      miso_o,      0);
    chk({tag, "_miso_oe"},   miso_oe_o,   0);
    chk({tag, "_wr_pulse"},  wr_pulse_o,  0);
    chk({tag, "_wr_addr"},   wr_addr_o,   0);
    chk({tag, "_wr_data"},   wr_data_o,   0);
    chk({tag, "_frame_err"}, frame_err_o, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  bit         t_mi, t_oe, t_m, t_abort;
  int         t_nfr, t_stop;
  logic [7:0] t_cmd;

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
    #20;
    chk_reset_outputs("reset");
    sweep("lcl_reset");
    prst_i = 1'b1;
    #(2*HALF);

    // Out-of-range write dropped, then a legal write to reg 5.
    ss_assert();
    frame(8'hD3, 8'h77, 0);
    frame(8'h85, 8'h46, 0);
    ss_release();
    sweep("lcl_after_wr5");

    // Preload reg 3 and read it back.
    ss_assert(); frame(8'h83, 8'hA5, 0); ss_release();
    ss_assert(); frame(8'h03, 8'h00, 0); ss_release();

    // Three back-to-back writes under one select.
    ss_assert();
    frame(8'h80, 8'h11, 0);
    frame(8'h81, 8'h22, 0);
    frame(8'h82, 8'h33, 0);
    ss_release();
    sweep("lcl_b2b");

    // Aborted write to reg 4 after data edge 13, then a full frame.
    ss_assert(); frame(8'h84, 8'h9C, 0); ss_release();
    ss_assert(); frame(8'h84, 8'hE1, 13);
    ss_assert(); frame(8'h86, 8'h5C, 0); ss_release();
    sweep("lcl_abort");

    // Randomized frames: mixed reads/writes, out-of-range addresses, aborts.
    for (int it = 0; it < 40; it++) begin
      ss_assert();
      t_nfr   = $urandom_range(1, 3);
      t_abort = 1'b0;
      for (int f = 0; f < t_nfr; f++) begin
        t_cmd  = {1'($urandom), 7'($urandom_range(0, 19))};
        t_stop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 16) : 0;
        frame(t_cmd, 8'($urandom), t_stop);
        if (t_stop != 0) begin
          t_abort = 1'b1;
          break;
        end
      end
      if (!t_abort) ss_release();
    end
    sweep("lcl_random");

    // Reset in the middle of a read of reg 3.
    ss_i = 1'b0;
    #(HALF);
    for (int e = 1; e <= 12; e++) begin
      t_m = (e <= 8) ? tx_bit(8'h03, e-1) : 1'b0;
      sclk_edge(t_m, t_mi, t_oe);
    end
    chk("oe_before_reset", miso_oe_o, 1);
    prst_i = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    #9;
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
    sweep("lcl_midreset");

    // Released with ss still low: this frame must be ignored.
    prst_i = 1'b1;
    #(HALF);
    for (int e = 1; e <= 17; e++) begin
      t_m = (e <= 8) ? tx_bit(8'h81, e-1) : 1'b1;
      sclk_edge(t_m, t_mi, t_oe);
    end
    #(HALF);
    ss_i = 1'b1;
    #(2*HALF);
    sweep("lcl_ignored_frame");

    // A normal frame after the select has cycled.
    ss_assert(); frame(8'h85, 8'h5A, 0); ss_release();
    ss_assert(); frame(8'h05, 8'h00, 0); ss_release();
    sweep("lcl_final");

    #(4*HALF);
    chk("ev_queue_drained", exp_ev_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_target_regs.md
# spi_target_regs

SPI target (slave) with an 8-bit register file, forming the far end of the SPI controller link. The block decodes address/data frames on mosi, stores write data in the register file and returns read data on miso. All SPI inputs are oversampled and edge-detected in the pclk domain. A local read port and a write-event strobe let system logic observe the registers.

## Interface
- DEPTH, 16: number of 8-bit registers; legal range 2..128.
- AW, 4: local address width, equal to clog2(DEPTH).
- pclk_i  in  1  system clock; the only clock in the block.
- prst_i  in  1  asynchronous, active-low reset.
- sclk_i  in  1  SPI clock from the controller; asynchronous to pclk_i; idles low.
- ss_i  in  1  target select, active-low; asynchronous.
- mosi_i  in  1  serial data from the controller.
- miso_o  out  1  serial data to the controller.
- miso_oe_o  out  1  miso output enable; high only during the read data phase.
- lcl_addr_i  in  AW  local read address.
- lcl_rdata_o  out  8  combinational read of reg[lcl_addr_i].
- wr_pulse_o  out  1  one-cycle strobe on every committed SPI write.
- wr_addr_o  out  7  address of the last SPI write, held until the next write.
- wr_data_o  out  8  data of the last SPI write, held until the next write.
- frame_err_o  out  1  one-cycle strobe on an aborted frame or an out-of-range access.

## Operation
- sclk_i, ss_i and mosi_i each pass through a 2-flop synchronizer. Rising and falling sclk edges are detected from the synchronized value.
- SPI mode 0:
  - mosi is sampled on sclk rising edges.
  - miso is updated on sclk falling edges.
- Frame format: 17 rising edges in total.
  - Edges 1-8: command byte. Bit 7 = 1 means write, 0 means read. Bits 6:0 are the address.
  - Edge 9: gap; mosi is ignored.
  - Edges 10-17: data byte.
- Bit order is LSB first by default; see Configuration.
- State machine (bit counter is 0..7):
  - S_IDLE: wait for ss_sync = 0, then go to S_CMD.
  - S_CMD: shift in 8 command bits, then go to S_GAP.
  - S_GAP: on the gap rising edge, snapshot the read data (reg[addr], or 8'h00 if out of range), then go to S_DATA.
  - S_DATA: shift 8 bits in (write) or out (read).
  - After the 8th data bit: commit the access, then return to S_CMD while ss stays low. Back-to-back frames under one ss assertion are allowed.
- Write commit: if addr < DEPTH, reg[addr] ← data, wr_pulse_o = 1 and wr_addr_o/wr_data_o are updated. If addr ≥ DEPTH, the write is dropped and frame_err_o pulses.
- Read of addr ≥ DEPTH: returns 8'h00 and frame_err_o pulses at the commit point.
- Read miso drive:
  - miso_oe_o rises on the falling edge after the gap edge; bit 0 of the snapshot is presented at that edge.
  - Each following falling edge presents the next bit.
  - miso_oe_o drops at the first falling edge after data edge 17, or immediately when ss rises.
  - Whenever miso_oe_o is 0, miso_o = 0.
- ss rising at any point other than a frame boundary (S_CMD with count 0) aborts the frame:
  - no commit;
  - frame_err_o pulses;
  - state returns to S_IDLE.
- sclk edges seen while ss_sync = 1 are ignored.

## Timing
- Reset values:
  - miso_o = 0, miso_oe_o = 0, wr_pulse_o = 0, wr_addr_o = 0, wr_data_o = 0, frame_err_o = 0.
  - All registers = 8'h00; state = S_IDLE; counter = 0.
- Input latency: 2 synchronizer cycles plus 1 edge-detect cycle. An action occurs 3 pclk after the pin edge.
- Write commit: wr_pulse_o and the register update happen in the same pclk cycle, 3 pclk after data rising edge 17. lcl_rdata_o reflects the new value in the following cycle.
- miso changes 3 pclk after an sclk falling edge. pclk must run at ≥ 8× the sclk frequency so miso is stable well before the next rising edge.
- frame_err_o timing:
  - abort: one pulse, 3 pclk after ss rises;
  - range error: one pulse in the commit cycle.
- Reset asserted mid-frame clears everything immediately. After reset releases, the first frame starts only after ss is seen high and then low again.

## Configuration
- SPI_TGT_MSB_FIRST_EN
  - Defined: command and data bytes are shifted MSB first, so bit 7 (the R/W flag) arrives on edge 1 and read data is sent bit 7 first.
  - Undefined (default): LSB first, matching the controller; the R/W flag arrives on edge 8.

## Test plan
- Write 8'hD3 (write flag, addr 7'h53 → out of range at DEPTH=16), then command 8'h85 with data 8'h46:
  - first frame is dropped and frame_err_o pulses;
  - second frame gives reg[5] = 8'h46, wr_pulse_o once, wr_addr_o = 7'h05, wr_data_o = 8'h46.
- Preload reg[3] = 8'hA5 by SPI write, then read command 8'h03: miso bits sampled on edges 10-17 give 8'hA5 LSB first; miso_oe_o is high only during that window.
- Three back-to-back frames under one ss assertion (writes to 0, 1, 2 with 8'h11, 8'h22, 8'h33): three wr_pulse_o strobes, and lcl_rdata_o returns each value.
- ss deasserted after data edge 13 of a write to reg[4]: reg[4] keeps its old value, frame_err_o pulses once, and a following full frame succeeds.
- Reset asserted mid read: all outputs go to their reset values at once, and lcl_rdata_o = 8'h00 for every address.
- With SPI_TGT_MSB_FIRST_EN defined: write command 8'h85 sent MSB first with data 8'h5A gives reg[5] = 8'h5A; reading reg[5] back returns 8'h5A MSB first.
